// File: rtl/dft_sample_loader_if.sv
// Sample stream (valid/ready) and compute-cache write bus of the DFT input stage.
// The slave modport is the loader; the master modport is the surrounding datapath.
`timescale 1ns/1ps
interface dft_sample_loader_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
);
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic              cache_we;
   logic [ADDR_W-1:0] cache_addr;
   logic [DATA_W-1:0] cache_wdata;

   modport master (
      output s_data, s_valid,
      input  s_ready, cache_we, cache_addr, cache_wdata
   );

   modport slave (
      input  s_data, s_valid,
      output s_ready, cache_we, cache_addr, cache_wdata
   );
endinterface

// File: rtl/dft_sample_loader.sv
// DFT input stage: captures a frame of samples into a local RAM, copies it to the
// compute cache on request, then holds the frame until the computation ends.
`timescale 1ns/1ps
module dft_sample_loader #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              ce,
   input  logic [ADDR_W-1:0] sample_num,
   output logic              data_loaded,
   input  logic              copy_start,
   output logic              data_to_cache_loaded,
   input  logic              calc_end,
   output logic              busy,
   dft_sample_loader_if.slave bus
);

   typedef enum logic [1:0] {FILL, LOADED, COPY, HOLD} state_t;

   localparam logic [ADDR_W-1:0] ONE = 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] n_q, n_d;
   logic              rd_done_q, rd_done_d;
   logic              rd_vld_q, rd_vld_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              cache_we_q, cache_we_d;
   logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
   logic [DATA_W-1:0] cache_wdata_q, cache_wdata_d;
   logic              data_loaded_q, data_loaded_d;
   logic              copied_q, copied_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] mem_rdata_q;

   logic              hs;
   logic              rd_en;
   logic [ADDR_W-1:0] n_eff;
   logic [ADDR_W-1:0] last_idx;

   assign bus.s_ready = ce && (state_q == FILL);
   assign hs          = bus.s_valid && bus.s_ready;
   assign rd_en       = (state_q == COPY) && !rd_done_q;
   // Frame length is taken from the port only on the first sample; 0 wraps to DEPTH.
   assign n_eff       = (wr_ptr_q == '0) ? sample_num : n_q;
   assign last_idx    = n_q - ONE;

   always_ff @(posedge clk) begin
      if (ce) begin
         if (hs && nrst) mem[wr_ptr_q] <= bus.s_data;
         if (rd_en)      mem_rdata_q   <= mem[rd_ptr_q];
      end
   end

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      n_d           = n_q;
      rd_done_d     = rd_done_q;
      rd_vld_d      = rd_en;
      rd_addr_d     = rd_en ? rd_ptr_q : rd_addr_q;
      cache_we_d    = rd_vld_q;
      cache_addr_d  = rd_vld_q ? rd_addr_q : cache_addr_q;
      cache_wdata_d = rd_vld_q ? mem_rdata_q : cache_wdata_q;
      data_loaded_d = 1'b0;
      copied_d      = 1'b0;

      case (state_q)
         FILL: begin
            if (hs) begin
               wr_ptr_d = wr_ptr_q + ONE;
               if (wr_ptr_q == '0) n_d = sample_num;
               if (wr_ptr_q == n_eff - ONE) begin
                  state_d       = LOADED;
                  data_loaded_d = 1'b1;
               end
            end
         end
         LOADED: begin
            if (copy_start) begin
               state_d   = COPY;
               rd_ptr_d  = '0;
               rd_done_d = 1'b0;
            end
         end
         COPY: begin
            if (rd_en) begin
               rd_ptr_d = rd_ptr_q + ONE;
               if (rd_ptr_q == last_idx) rd_done_d = 1'b1;
            end
            // Cache addresses rise monotonically, so the first write at last_idx is the final one.
            if (cache_we_q && (cache_addr_q == last_idx)) begin
               state_d  = HOLD;
               copied_d = 1'b1;
            end
         end
         HOLD: begin
            if (calc_end) begin
               state_d  = FILL;
               wr_ptr_d = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q       <= FILL;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         n_q           <= '0;
         rd_done_q     <= 1'b0;
         rd_vld_q      <= 1'b0;
         rd_addr_q     <= '0;
         cache_we_q    <= 1'b0;
         cache_addr_q  <= '0;
         cache_wdata_q <= '0;
         data_loaded_q <= 1'b0;
         copied_q      <= 1'b0;
      end else if (ce) begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         n_q           <= n_d;
         rd_done_q     <= rd_done_d;
         rd_vld_q      <= rd_vld_d;
         rd_addr_q     <= rd_addr_d;
         cache_we_q    <= cache_we_d;
         cache_addr_q  <= cache_addr_d;
         cache_wdata_q <= cache_wdata_d;
         data_loaded_q <= data_loaded_d;
         copied_q      <= copied_d;
      end
   end

   assign bus.cache_we          = cache_we_q;
   assign bus.cache_addr        = cache_addr_q;
   assign bus.cache_wdata       = cache_wdata_q;
   assign data_loaded           = data_loaded_q;
   assign data_to_cache_loaded  = copied_q;
   assign busy                  = (state_q != FILL);

endmodule

// File: tb/tb_dft_sample_loader.sv
// Randomized bench for dft_sample_loader: a frame-level model (queue of accepted
// samples, ce-cycle counters) predicts handshakes, pulses and cache writes.
`timescale 1ns/1ps
module tb_dft_sample_loader;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 12;
   localparam int DEPTH  = 4096;

   logic              clk = 1'b0;
   logic              nrst;
   logic              ce;
   logic [ADDR_W-1:0] sample_num;
   logic              data_loaded;
   logic              copy_start;
   logic              data_to_cache_loaded;
   logic              calc_end;
   logic              busy;

   dft_sample_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   dft_sample_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .nrst                 (nrst),
      .ce                   (ce),
      .sample_num           (sample_num),
      .data_loaded          (data_loaded),
      .copy_start           (copy_start),
      .data_to_cache_loaded (data_to_cache_loaded),
      .calc_end             (calc_end),
      .busy                 (busy),
      .bus                  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   logic [DATA_W-1:0] frame[$];
   int   exp_addr;
   logic exp_dl;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      nrst = 1'b0; ce = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0;
      copy_start = 1'b0; calc_end = 1'b0; sample_num = '0;
      step();
      step();
      nrst = 1'b1;
      exp_addr = 0;
      exp_dl = 1'b0;
      frame.delete();
   endtask

   // Streams one frame; the model accepts while fewer than N samples have been taken.
   task automatic load_frame(input logic [ADDR_W-1:0] n_field, input bit seq,
                             input bit change_num, input int gap_at);
      int n;
      int got = 0;
      int cyc = 0;
      logic hs;
      n = (n_field == '0) ? DEPTH : int'(n_field);
      frame.delete();
      while (got < n && cyc < 4 * n + 100) begin
         bus.s_valid = seq ? 1'b1 : ($urandom_range(0, 3) != 0);
         bus.s_data  = seq ? DATA_W'(got + 1) : DATA_W'($urandom);
         ce          = !(gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 3);
         sample_num  = (change_num && got > 0) ? ADDR_W'(8) : n_field;
         #1;
         checks++;
         if (bus.s_ready !== ce) begin
            fails++;
            $display("FAIL fill_s_ready cyc=%0d: got %0b expected %0b", cyc, bus.s_ready, ce);
         end
         hs = ce && bus.s_valid;
         if (hs) begin
            frame.push_back(bus.s_data);
            got++;
         end
         step();
         if (ce) exp_dl = hs && (got == n);
         checks++;
         if (data_loaded !== exp_dl) begin
            fails++;
            $display("FAIL data_loaded cyc=%0d: got %0b expected %0b", cyc, data_loaded, exp_dl);
         end
         checks++;
         if (busy !== (got == n)) begin
            fails++;
            $display("FAIL fill_busy cyc=%0d: got %0b expected %0b", cyc, busy, got == n);
         end
         cyc++;
      end
      checks++;
      if (got != n) begin
         fails++;
         $display("FAIL fill_timeout: got %0d handshakes expected %0d", got, n);
      end
      bus.s_valid = 1'b1;
      ce = 1'b1;
      #1;
      checks++;
      if (bus.s_ready !== 1'b0) begin
         fails++;
         $display("FAIL loaded_s_ready: got %0b expected 0", bus.s_ready);
      end
      step();
      exp_dl = 1'b0;
      checks++;
      if (data_loaded !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL loaded_state: data_loaded %0b busy %0b expected 0 1", data_loaded, busy);
      end
      bus.s_valid = 1'b0;
   endtask

   // Cache write k (from 0) follows the (k+2)-th ce=1 edge after copy_start is sampled.
   task automatic copy_frame(input bit hold_start, input int gap_at, input bit with_calc_end);
      int   n;
      int   k = 0;
      int   cyc = 0;
      logic exp_we = 1'b0;
      logic exp_dtcl = 1'b0;
      n = frame.size();
      copy_start = 1'b1; calc_end = with_calc_end; ce = 1'b1;
      step();
      checks++;
      if (busy !== 1'b1 || bus.cache_we !== 1'b0 || data_to_cache_loaded !== 1'b0) begin
         fails++;
         $display("FAIL copy_e0: busy %0b we %0b dtcl %0b expected 1 0 0",
                  busy, bus.cache_we, data_to_cache_loaded);
      end
      copy_start = hold_start;
      calc_end = 1'b0;
      while (k < n + 2 && cyc < n + 30) begin
         ce = !(gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 3);
         step();
         if (ce) begin
            k++;
            exp_we = (k >= 2 && k <= n + 1);
            if (exp_we) exp_addr = k - 2;
            exp_dtcl = (k == n + 2);
         end
         checks++;
         if (bus.cache_we !== exp_we) begin
            fails++;
            $display("FAIL cache_we k=%0d: got %0b expected %0b", k, bus.cache_we, exp_we);
         end
         checks++;
         if (bus.cache_addr !== ADDR_W'(exp_addr)) begin
            fails++;
            $display("FAIL cache_addr k=%0d: got %0d expected %0d", k, bus.cache_addr, exp_addr);
         end
         if (exp_we) begin
            checks++;
            if (bus.cache_wdata !== frame[exp_addr]) begin
               fails++;
               $display("FAIL cache_wdata addr=%0d: got %h expected %h",
                        exp_addr, bus.cache_wdata, frame[exp_addr]);
            end
         end
         checks++;
         if (data_to_cache_loaded !== exp_dtcl) begin
            fails++;
            $display("FAIL copy_done k=%0d: got %0b expected %0b", k, data_to_cache_loaded, exp_dtcl);
         end
         cyc++;
      end
      checks++;
      if (k != n + 2) begin
         fails++;
         $display("FAIL copy_timeout: got %0d ce cycles expected %0d", k, n + 2);
      end
      copy_start = 1'b0;
      ce = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b1 || bus.s_ready !== 1'b0) begin
         fails++;
         $display("FAIL hold_state: busy %0b s_ready %0b expected 1 0", busy, bus.s_ready);
      end
   endtask

   task automatic release_hold();
      calc_end = 1'b1; ce = 1'b1;
      step();
      calc_end = 1'b0;
      checks++;
      if (busy !== 1'b0 || bus.s_ready !== 1'b1) begin
         fails++;
         $display("FAIL release: busy %0b s_ready %0b expected 0 1", busy, bus.s_ready);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (bus.s_ready !== 1'b1 || data_loaded !== 1'b0 || bus.cache_we !== 1'b0 ||
          bus.cache_addr !== '0 || bus.cache_wdata !== '0 ||
          data_to_cache_loaded !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_values: rdy %0b dl %0b we %0b addr %0d wd %h dtcl %0b busy %0b",
                  bus.s_ready, data_loaded, bus.cache_we, bus.cache_addr, bus.cache_wdata,
                  data_to_cache_loaded, busy);
      end
      ce = 1'b0;
      #1;
      checks++;
      if (bus.s_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready_ce0: got %0b expected 0", bus.s_ready);
      end
      ce = 1'b1;
   endtask

   task automatic test_basic();
      load_frame(ADDR_W'(4), 1'b1, 1'b0, -1);
      copy_frame(1'b0, -1, 1'b0);
      release_hold();
   endtask

   task automatic test_num_change();
      load_frame(ADDR_W'(4), 1'b1, 1'b1, -1);
      calc_end = 1'b1;
      step();
      calc_end = 1'b0;
      step();
      checks++;
      if (busy !== 1'b1 || bus.s_ready !== 1'b0 || bus.cache_we !== 1'b0) begin
         fails++;
         $display("FAIL calc_end_in_loaded: busy %0b rdy %0b we %0b expected 1 0 0",
                  busy, bus.s_ready, bus.cache_we);
      end
      copy_frame(1'b1, -1, 1'b1);
      copy_start = 1'b1;
      step();
      step();
      copy_start = 1'b0;
      checks++;
      if (bus.cache_we !== 1'b0 || data_to_cache_loaded !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL copy_start_in_hold: we %0b dtcl %0b busy %0b expected 0 0 1",
                  bus.cache_we, data_to_cache_loaded, busy);
      end
      release_hold();
   endtask

   task automatic test_ce_freeze();
      load_frame(ADDR_W'(8), 1'b0, 1'b0, 3);
      copy_frame(1'b0, 4, 1'b0);
      release_hold();
   endtask

   task automatic test_full_depth();
      load_frame('0, 1'b0, 1'b0, -1);
      copy_frame(1'b0, -1, 1'b0);
      checks++;
      if (bus.cache_addr !== ADDR_W'(12'hFFF)) begin
         fails++;
         $display("FAIL full_last_addr: got %h expected fff", bus.cache_addr);
      end
      release_hold();
   endtask

   task automatic test_reset_mid_copy();
      load_frame(ADDR_W'(8), 1'b0, 1'b0, -1);
      copy_start = 1'b1;
      step();
      copy_start = 1'b0;
      step();
      step();
      step();
      checks++;
      if (bus.cache_we !== 1'b1 || bus.cache_addr !== ADDR_W'(1)) begin
         fails++;
         $display("FAIL mid_copy_write2: we %0b addr %0d expected 1 1", bus.cache_we, bus.cache_addr);
      end
      nrst = 1'b0;
      step();
      nrst = 1'b1;
      exp_addr = 0;
      exp_dl = 1'b0;
      checks++;
      if (bus.s_ready !== 1'b1 || data_loaded !== 1'b0 || bus.cache_we !== 1'b0 ||
          bus.cache_addr !== '0 || bus.cache_wdata !== '0 ||
          data_to_cache_loaded !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL mid_copy_reset: rdy %0b dl %0b we %0b addr %0d wd %h dtcl %0b busy %0b",
                  bus.s_ready, data_loaded, bus.cache_we, bus.cache_addr, bus.cache_wdata,
                  data_to_cache_loaded, busy);
      end
      load_frame(ADDR_W'(8), 1'b0, 1'b0, -1);
      copy_frame(1'b0, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      bus.s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.s_data = DATA_W'($urandom);
         #1;
         checks++;
         if (bus.s_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_s_ready i=%0d: got %0b expected 0", i, bus.s_ready);
         end
         step();
         checks++;
         if (data_loaded !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL hold_accept i=%0d: dl %0b busy %0b expected 0 1", i, data_loaded, busy);
         end
      end
      bus.s_valid = 1'b0;
      release_hold();
      load_frame(ADDR_W'($urandom_range(2, 16)), 1'b0, 1'b0, -1);
      copy_frame(1'b0, -1, 1'b0);
      release_hold();
      load_frame(ADDR_W'(1), 1'b0, 1'b0, -1);
      copy_frame(1'b0, -1, 1'b0);
      release_hold();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_num_change();
      test_ce_freeze();
      test_full_depth();
      test_reset_mid_copy();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", checks, fails);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dft_sample_loader.md
# dft_sample_loader

Input stage of the DFT datapath. Captures a frame of `sample_num` samples from a valid/ready stream into an internal sample RAM and signals `data_loaded` to the control FSM. On `copy_start` it copies the frame into the compute cache and signals `data_to_cache_loaded`. It then holds off the next frame until the FSM reports `calc_end`.

## Interface
Parameters:
- `DATA_W`, 16, sample width (signed, two's complement; stored verbatim).
- `ADDR_W`, 12, sample RAM / cache address width.
- `DEPTH`, 4096, sample RAM depth; must equal 2^ADDR_W.

Ports:
- `clk`  in  1  clock.
- `nrst`  in  1  reset; synchronous, active-low.
- `ce`  in  1  clock enable; when low, all registers hold.
- `sample_num`  in  12  frame length N; 0 encodes DEPTH (4096).
- `s_data`  in  DATA_W  input sample.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  loader accepts a sample this cycle.
- `data_loaded`  out  1  one-cycle pulse: frame captured.
- `copy_start`  in  1  level; FSM requests the cache copy.
- `cache_we`  out  1  cache write enable.
- `cache_addr`  out  ADDR_W  cache write address.
- `cache_wdata`  out  DATA_W  cache write data.
- `data_to_cache_loaded`  out  1  one-cycle pulse: copy complete.
- `calc_end`  in  1  FSM pulse: computation finished, frame may be overwritten.
- `busy`  out  1  high in any state other than FILL.

## Operation
- States: FILL, LOADED, COPY, HOLD. Reset enters FILL with wr_ptr=0 and rd_ptr=0.
- State changes occur only on edges where `ce`=1. A "cycle" below means a `ce`=1 cycle.
- `s_ready` is combinational: `ce` AND (state==FILL). A handshake is `s_valid` AND `s_ready`.
- FILL:
  - On each handshake, write `s_data` to mem[wr_ptr] and increment wr_ptr.
  - On the first handshake of a frame (wr_ptr==0), latch `sample_num` into n_reg. `sample_num` is ignored at all other times.
  - The handshake with wr_ptr==n_reg-1 moves to LOADED and pulses `data_loaded`. For n_reg=0 this happens at wr_ptr==4095.
- LOADED: `s_ready`=0. When `copy_start`=1, move to COPY and clear rd_ptr.
- COPY:
  - RAM read is synchronous with 1-cycle latency. Issue reads for addresses 0..N-1 on consecutive cycles.
  - Each read result drives `cache_we`=1, `cache_addr`=its address, `cache_wdata`=its data, one cycle after the read.
  - The cycle after the last write, pulse `data_to_cache_loaded` and move to HOLD.
  - Dropping `copy_start` mid-copy has no effect.
- HOLD: `s_ready`=0. On `calc_end`=1, move to FILL with wr_ptr=0.
- `calc_end` in any state other than HOLD is ignored.
- `copy_start` in any state other than LOADED is ignored.
- Input samples offered outside FILL are not accepted (`s_ready`=0). The loader never drops or overwrites data.

## Timing
- Reset values:
  - `s_ready`=`ce` (state FILL).
  - `data_loaded`=0, `cache_we`=0, `cache_addr`=0, `cache_wdata`=0, `data_to_cache_loaded`=0, `busy`=0.
- `data_loaded` is high for exactly one cycle, immediately after the edge that accepts sample N-1.
- Copy latency:
  - `copy_start` sampled at edge E0.
  - `cache_we` is high for N consecutive cycles following edges E2..E(N+1).
  - `data_to_cache_loaded` is high following edge E(N+2).
  - Total copy time: N+2 cycles.
- `cache_addr` increments by 1 per write, starting at 0. It holds its last value when `cache_we`=0.
- `ce`=0:
  - All state, pointers and outputs freeze. A pulse active when `ce` drops stays high until the next `ce`=1 edge.
  - `cache_we` freezes too, so the cache must also honour `ce`.
- `nrst`=0 in any state (including mid-COPY) returns to the reset state on the next edge.
  - Any partially written cache contents are undefined.
  - Any partially captured frame is discarded.
- `calc_end` and `copy_start` high together: only the input relevant to the current state acts.

## Test plan
- Reset, N=4, stream 0x0001..0x0004 with `s_valid` held high:
  - 4 handshakes; `data_loaded` pulses once on the cycle after the 4th.
  - `s_ready`=0 afterwards; `busy`=1.
- In LOADED, assert `copy_start` for 1 cycle:
  - `cache_we` high for 4 cycles, starting 2 cycles later, with addr 0..3 and data 0x0001..0x0004.
  - `data_to_cache_loaded` pulses on the next cycle.
- `sample_num`=0 with a random stream:
  - Exactly 4096 handshakes before `data_loaded`.
  - Copy writes addr 0..4095; the last write is at addr 0xFFF.
- Change `sample_num` from 4 to 8 after the first sample is accepted: frame still ends after 4 samples. Pulse `calc_end` in LOADED: ignored, state unchanged.
- Toggle `ce` low for 3 cycles mid-FILL and mid-COPY:
  - No handshakes during those cycles; `cache_we`/`cache_addr` frozen.
  - Final cache contents match the input stream; total copy takes N+2 `ce`=1 cycles.
- Assert `nrst`=0 at copy write 2 of N=8:
  - All outputs return to reset values; `s_ready`=1.
  - A fresh 8-sample frame loads and copies correctly. A second frame is accepted only after `calc_end` in HOLD.
